// File: rtl/eq_pkg.sv
// Shared widths, encodings, state type and fixed-point helpers for the EQ band scheduler.
package eq_pkg;
    localparam int W         = 18;
    localparam int FRAC      = 16;
    localparam int NUM_BANDS = 4;
    localparam int ACC_W     = 21;
    localparam int PROD_W    = 2 * W;

    localparam logic signed [W-1:0] SAT_MAX = 18'sh1FFFF;
    localparam logic signed [W-1:0] SAT_MIN = 18'sh20000;
    localparam logic signed [W-1:0] UNITY   = 18'sh10000;

    typedef enum logic [2:0] {
        SEL_A1 = 3'd0,
        SEL_A2 = 3'd1,
        SEL_B0 = 3'd2,
        SEL_B1 = 3'd3,
        SEL_B2 = 3'd4
    } coef_sel_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic signed [W-1:0] a1;
        logic signed [W-1:0] a2;
        logic signed [W-1:0] b0;
        logic signed [W-1:0] b1;
        logic signed [W-1:0] b2;
    } coef_t;

    function automatic logic signed [W-1:0] sat_w(input logic signed [PROD_W-1:0] v);
        if (v > PROD_W'(SAT_MAX)) return SAT_MAX;
        if (v < PROD_W'(SAT_MIN)) return SAT_MIN;
        return v[W-1:0];
    endfunction

    // Q2.16 x Q2.16 gives Q4.32; dropping FRAC bits returns to Q2.16 before clamping.
    function automatic logic signed [W-1:0] mul_term(input logic signed [W-1:0] c,
                                                     input logic signed [W-1:0] x);
        logic signed [PROD_W-1:0] p;
        p = PROD_W'(c) * PROD_W'(x);
        return sat_w(p >>> FRAC);
    endfunction

    function automatic coef_t passthrough(input int band);
        coef_t c;
        c = '0;
        if (band == 0) c.b0 = UNITY;
        return c;
    endfunction
endpackage

// File: rtl/eq_band_scheduler_if.sv
// Sample stream between a source and the EQ scheduler. uk moves on a rising edge where
// uk_valid and uk_ready are both high; uk_valid while uk_ready is low is dropped, not held.
interface eq_band_scheduler_if;
    import eq_pkg::*;

    logic signed [W-1:0] uk;
    logic                uk_valid;
    logic                uk_ready;
    logic signed [W-1:0] yk;
    logic                yk_valid;

    modport master (output uk, output uk_valid, input uk_ready, input yk, input yk_valid);
    modport slave  (input uk, input uk_valid, output uk_ready, output yk, output yk_valid);
endinterface

// File: rtl/biquad_step.sv
// One direct-form-II biquad evaluation for a single band; purely combinational.
module biquad_step
    import eq_pkg::*;
(
    input  logic signed [W-1:0] uk,
    input  logic signed [W-1:0] fk1,
    input  logic signed [W-1:0] fk2,
    input  coef_t               c,
    output logic signed [W-1:0] fk,
    output logic signed [W-1:0] yb
);
    always_comb begin
        fk = sat_w(PROD_W'(uk) + PROD_W'(mul_term(c.a1, fk1)) + PROD_W'(mul_term(c.a2, fk2)));
        yb = sat_w(PROD_W'(mul_term(c.b0, fk)) + PROD_W'(mul_term(c.b1, fk1))
                   + PROD_W'(mul_term(c.b2, fk2)));
    end
endmodule

// File: rtl/eq_band_scheduler.sv
// Four-band equalizer sharing one biquad datapath, one band per clock, with
// double-buffered coefficients that only swap between samples.
module eq_band_scheduler
    import eq_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    eq_band_scheduler_if.slave          io,
    input  logic                        cfg_we,
    input  logic [1:0]                  cfg_band,
    input  logic [2:0]                  cfg_sel,
    input  logic signed [W-1:0]         cfg_data,
    input  logic                        cfg_commit,
    output logic                        overrun,
    output state_e                      dbg_state,
    output logic [1:0]                  dbg_band,
    output logic [NUM_BANDS-1:0][W-1:0] dbg_fk1,
    output logic [NUM_BANDS-1:0][W-1:0] dbg_fk2
);
    localparam logic [1:0] LAST_BAND = 2'(NUM_BANDS - 1);

    state_e                  state_q, state_d;
    logic [1:0]              band_q, band_d;
    logic signed [W-1:0]     uk_q, uk_d;
    logic signed [W-1:0]     yk_q, yk_d;
    logic                    yk_valid_q, yk_valid_d;
    logic                    overrun_q, overrun_d;
    logic                    pending_q, pending_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [W-1:0]     fk1_q [NUM_BANDS];
    logic signed [W-1:0]     fk1_d [NUM_BANDS];
    logic signed [W-1:0]     fk2_q [NUM_BANDS];
    logic signed [W-1:0]     fk2_d [NUM_BANDS];
    coef_t                   shadow_q [NUM_BANDS];
    coef_t                   shadow_d [NUM_BANDS];
    coef_t                   active_q [NUM_BANDS];
    coef_t                   active_d [NUM_BANDS];

    logic signed [W-1:0]     fk_w, yb_w;
    logic signed [ACC_W-1:0] acc_sum;

    biquad_step u_step (
        .uk  (uk_q),
        .fk1 (fk1_q[band_q]),
        .fk2 (fk2_q[band_q]),
        .c   (active_q[band_q]),
        .fk  (fk_w),
        .yb  (yb_w)
    );

    // Band 0 starts a fresh sum so the accumulator never needs an explicit clear.
    assign acc_sum = ((band_q == 2'd0) ? '0 : acc_q) + ACC_W'(yb_w);

    always_comb begin
        state_d    = state_q;
        band_d     = band_q;
        uk_d       = uk_q;
        acc_d      = acc_q;
        yk_d       = yk_q;
        yk_valid_d = 1'b0;
        overrun_d  = overrun_q;
        pending_d  = pending_q;
        fk1_d      = fk1_q;
        fk2_d      = fk2_q;
        shadow_d   = shadow_q;
        active_d   = active_q;

        if (cfg_we) begin
            case (cfg_sel)
                SEL_A1:  shadow_d[cfg_band].a1 = cfg_data;
                SEL_A2:  shadow_d[cfg_band].a2 = cfg_data;
                SEL_B0:  shadow_d[cfg_band].b0 = cfg_data;
                SEL_B1:  shadow_d[cfg_band].b1 = cfg_data;
                SEL_B2:  shadow_d[cfg_band].b2 = cfg_data;
                default: ;
            endcase
        end

        if (io.uk_valid && state_q != IDLE) overrun_d = 1'b1;

        // Commits copy shadow_d, so a write landing on the commit edge is included.
        case (state_q)
            IDLE: begin
                if (io.uk_valid) begin
                    uk_d    = io.uk;
                    band_d  = '0;
                    state_d = RUN;
                end
                if (cfg_commit) active_d = shadow_d;
            end
            RUN: begin
                fk1_d[band_q] = fk_w;
                fk2_d[band_q] = fk1_q[band_q];
                acc_d         = acc_sum;
                band_d        = band_q + 2'd1;
                if (cfg_commit) pending_d = 1'b1;
                if (band_q == LAST_BAND) begin
                    state_d    = DONE;
                    yk_d       = sat_w(PROD_W'(acc_sum));
                    yk_valid_d = 1'b1;
                end
            end
            DONE: begin
                state_d   = IDLE;
                pending_d = 1'b0;
                if (pending_q || cfg_commit) active_d = shadow_d;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            band_q     <= '0;
            uk_q       <= '0;
            acc_q      <= '0;
            yk_q       <= '0;
            yk_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
            pending_q  <= 1'b0;
            for (int b = 0; b < NUM_BANDS; b++) begin
                fk1_q[b]    <= '0;
                fk2_q[b]    <= '0;
                shadow_q[b] <= passthrough(b);
                active_q[b] <= passthrough(b);
            end
        end else begin
            state_q    <= state_d;
            band_q     <= band_d;
            uk_q       <= uk_d;
            acc_q      <= acc_d;
            yk_q       <= yk_d;
            yk_valid_q <= yk_valid_d;
            overrun_q  <= overrun_d;
            pending_q  <= pending_d;
            fk1_q      <= fk1_d;
            fk2_q      <= fk2_d;
            shadow_q   <= shadow_d;
            active_q   <= active_d;
        end
    end

    assign io.uk_ready = (state_q == IDLE);
    assign io.yk       = yk_q;
    assign io.yk_valid = yk_valid_q;
    assign overrun     = overrun_q;
    assign dbg_state   = state_q;
    assign dbg_band    = band_q;

    always_comb begin
        for (int b = 0; b < NUM_BANDS; b++) begin
            dbg_fk1[b] = fk1_q[b];
            dbg_fk2[b] = fk2_q[b];
        end
    end
endmodule
